// File: rtl/vc_credit_tracker.sv
// Per-output-port, per-VC credit counters with VC occupancy tracking.
// Produces registered blocked/free vectors, indexed p*NV+v, plus a sticky protocol-error flag.
module vc_credit_tracker #(
  parameter int NP        = 5,
  parameter int NV        = 4,
  parameter int BUF_DEPTH = 4,
  parameter int CNT_W     = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flit_sent,
  input  logic [NP-1:0]         flit_port,
  input  logic [NV-1:0]         flit_vc,
  input  logic                  flit_tail,
  input  logic [NP-1:0]         credit_valid,
  input  logic [NP*NV-1:0]      credit_vc,
  input  logic [NP*NV-1:0]      vc_alloc,
  output logic [NP*NV-1:0]      vc_blocked,
  output logic [NP*NV-1:0]      vc_free,
  output logic [NP*NV*CNT_W-1:0] credit_count,
  output logic                  error
);

  localparam int N = NP * NV;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(BUF_DEPTH);

  function automatic logic onehot_p(input logic [NP-1:0] x);
    return (x != '0) && ((x & (x - NP'(1))) == '0);
  endfunction

  function automatic logic onehot_v(input logic [NV-1:0] x);
    return (x != '0) && ((x & (x - NV'(1))) == '0);
  endfunction

  // VC state per entry: FREE (free=1), BUSY (free=0, pend=0), DRAINING (free=0, pend=1).
  logic [CNT_W-1:0] cnt_q [N];
  logic [CNT_W-1:0] cnt_d [N];
  logic [N-1:0]     blk_q, blk_d;
  logic [N-1:0]     free_q, free_d;
  logic [N-1:0]     pend_q, pend_d;
  logic             err_q, err_d;

  logic             send_ok;
  logic [NP-1:0]    credit_ok;
  logic [N-1:0]     dec, inc;

  // Malformed sends and credits are dropped before they reach any counter.
  always_comb begin
    send_ok = flit_sent && onehot_p(flit_port) && onehot_v(flit_vc);
    for (int p = 0; p < NP; p++) begin
      credit_ok[p] = credit_valid[p] && onehot_v(credit_vc[p*NV +: NV]);
    end
    for (int p = 0; p < NP; p++) begin
      for (int v = 0; v < NV; v++) begin
        dec[p*NV+v] = send_ok && flit_port[p] && flit_vc[v];
        inc[p*NV+v] = credit_ok[p] && credit_vc[p*NV+v];
      end
    end
  end

  always_comb begin
    err_d = err_q;
    if (flit_sent && !send_ok) err_d = 1'b1;
    for (int p = 0; p < NP; p++) begin
      if (credit_valid[p] && !credit_ok[p]) err_d = 1'b1;
    end
    for (int i = 0; i < N; i++) begin
      cnt_d[i]  = cnt_q[i];
      free_d[i] = free_q[i];
      pend_d[i] = pend_q[i];
      if (dec[i] && !inc[i]) begin
        if (cnt_q[i] == '0) err_d = 1'b1;
        else cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end else if (inc[i] && !dec[i]) begin
        if (cnt_q[i] == FULL) err_d = 1'b1;
        else cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
      if (dec[i] && free_q[i]) err_d = 1'b1;
      if (free_q[i]) begin
        if (vc_alloc[i]) free_d[i] = 1'b0;
      end else begin
        if (vc_alloc[i]) err_d = 1'b1;
        // Release only once the tail is gone and every slot has been credited back.
        if (pend_q[i]) begin
          if (cnt_d[i] == FULL) begin
            free_d[i] = 1'b1;
            pend_d[i] = 1'b0;
          end
        end else if (dec[i] && flit_tail) begin
          if (cnt_d[i] == FULL) free_d[i] = 1'b1;
          else pend_d[i] = 1'b1;
        end
      end
      blk_d[i] = (cnt_d[i] == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) cnt_q[i] <= FULL;
      blk_q  <= '0;
      free_q <= '1;
      pend_q <= '0;
      err_q  <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
      blk_q  <= blk_d;
      free_q <= free_d;
      pend_q <= pend_d;
      err_q  <= err_d;
    end
  end

  assign vc_blocked = blk_q;
  assign vc_free    = free_q;
  assign error      = err_q;

  for (genvar g = 0; g < N; g++) begin : g_cnt
    assign credit_count[g*CNT_W +: CNT_W] = cnt_q[g];
  end

endmodule

// File: tb/tb_vc_credit_tracker.sv
// Directed table-driven bench for vc_credit_tracker (NP=5, NV=4, BUF_DEPTH=4),
// followed by a hand-written mid-packet reset sequence.
module tb_vc_credit_tracker;

  localparam int NP = 5;
  localparam int NV = 4;
  localparam int N  = NP * NV;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          flit_sent;
  logic [NP-1:0] flit_port;
  logic [NV-1:0] flit_vc;
  logic          flit_tail;
  logic [NP-1:0] credit_valid;
  logic [N-1:0]  credit_vc;
  logic [N-1:0]  vc_alloc;
  logic [N-1:0]  vc_blocked;
  logic [N-1:0]  vc_free;
  logic [N*CW-1:0] credit_count;
  logic          error;

  int total = 0;
  int bad   = 0;

  logic [CW-1:0] exp_q[$];

  typedef struct {
    logic          rst;
    logic          sent;
    logic [NP-1:0] port;
    logic [NV-1:0] vc;
    logic          tail;
    logic [NP-1:0] cval;
    logic [N-1:0]  cvc;
    logic [N-1:0]  alloc;
    logic [N-1:0]  e_blk;
    logic [N-1:0]  e_free;
    logic          e_err;
    int            idx;
    logic [CW-1:0] e_cnt;
    logic          all4;
  } vec_t;

  vec_t vec_q[$];

  vc_credit_tracker #(.NP(NP), .NV(NV), .BUF_DEPTH(4), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .flit_sent    (flit_sent),
    .flit_port    (flit_port),
    .flit_vc      (flit_vc),
    .flit_tail    (flit_tail),
    .credit_valid (credit_valid),
    .credit_vc    (credit_vc),
    .vc_alloc     (vc_alloc),
    .vc_blocked   (vc_blocked),
    .vc_free      (vc_free),
    .credit_count (credit_count),
    .error        (error)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic add(input logic r, input logic s, input logic [NP-1:0] port,
                     input logic [NV-1:0] vc, input logic t, input logic [NP-1:0] cval,
                     input logic [N-1:0] cvc, input logic [N-1:0] alloc,
                     input logic [N-1:0] eblk, input logic [N-1:0] efree, input logic eerr,
                     input int idx, input logic [CW-1:0] ecnt, input logic all4);
    vec_t v;
    v.rst = r; v.sent = s; v.port = port; v.vc = vc; v.tail = t;
    v.cval = cval; v.cvc = cvc; v.alloc = alloc;
    v.e_blk = eblk; v.e_free = efree; v.e_err = eerr;
    v.idx = idx; v.e_cnt = ecnt; v.all4 = all4;
    vec_q.push_back(v);
  endtask

  // driver: inputs change on the falling edge, outputs sampled 1 time unit after the rising edge
  task automatic drive(input logic r, input logic s, input logic [NP-1:0] port,
                       input logic [NV-1:0] vc, input logic t, input logic [NP-1:0] cval,
                       input logic [N-1:0] cvc, input logic [N-1:0] alloc);
    @(negedge clk);
    rst = r; flit_sent = s; flit_port = port; flit_vc = vc; flit_tail = t;
    credit_valid = cval; credit_vc = cvc; vc_alloc = alloc;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic chk_all4(input string name);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (credit_count[i*CW +: CW] !== 3'd4) ok = 1'b0;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: credit_count=0x%0h expected every entry 4", name, credit_count);
    end
  endtask

  initial begin
    rst = 1'b1; flit_sent = 1'b0; flit_port = '0; flit_vc = '0; flit_tail = 1'b0;
    credit_valid = '0; credit_vc = '0; vc_alloc = '0;

    //  rst sent port      vc       tail cval      cvc        alloc      e_blk      e_free     err idx cnt all4
    // reset
    add(1, 0, 5'b00000, 4'b0000, 0, 5'b00000, 20'h00000, 20'h00000, 20'h00000, 20'hFFFFF, 0, 0, 4, 1);
    add(1, 0, 5'b00000, 4'b0000, 0, 5'b00000, 20'h00000, 20'h00000, 20'h00000, 20'hFFFFF, 0, 0, 4, 1);
    // drain entry 6 (port1, VC2) to blocked, then underflow
    add(0, 0, 5'b00000, 4'b0000, 0, 5'b00000, 20'h00000, 20'h00040, 20'h00000, 20'hFFFBF, 0, 6, 4, 0);
    add(0, 1, 5'b00010, 4'b0100, 0, 5'b00000, 20'h00000, 20'h00000, 20'h00000, 20'hFFFBF, 0, 6, 3, 0);
    add(0, 1, 5'b00010, 4'b0100, 0, 5'b00000, 20'h00000, 20'h00000, 20'h00000, 20'hFFFBF, 0, 6, 2, 0);
    add(0, 1, 5'b00010, 4'b0100, 0, 5'b00000, 20'h00000, 20'h00000, 20'h00000, 20'hFFFBF, 0, 6, 1, 0);
    add(0, 1, 5'b00010, 4'b0100, 0, 5'b00000, 20'h00000, 20'h00000, 20'h00040, 20'hFFFBF, 0, 6, 0, 0);
    add(0, 1, 5'b00010, 4'b0100, 0, 5'b00000, 20'h00000, 20'h00000, 20'h00040, 20'hFFFBF, 1, 6, 0, 0);
    add(1, 0, 5'b00000, 4'b0000, 0, 5'b00000, 20'h00000, 20'h00000, 20'h00000, 20'hFFFFF, 0, 6, 4, 1);
    // send and credit together at count 1
    add(0, 0, 5'b00000, 4'b0000, 0, 5'b00000, 20'h00000, 20'h00040, 20'h00000, 20'hFFFBF, 0, 6, 4, 0);
    add(0, 1, 5'b00010, 4'b0100, 0, 5'b00000, 20'h00000, 20'h00000, 20'h00000, 20'hFFFBF, 0, 6, 3, 0);
    add(0, 1, 5'b00010, 4'b0100, 0, 5'b00000, 20'h00000, 20'h00000, 20'h00000, 20'hFFFBF, 0, 6, 2, 0);
    add(0, 1, 5'b00010, 4'b0100, 0, 5'b00000, 20'h00000, 20'h00000, 20'h00000, 20'hFFFBF, 0, 6, 1, 0);
    add(0, 1, 5'b00010, 4'b0100, 0, 5'b00010, 20'h00040, 20'h00000, 20'h00000, 20'hFFFBF, 0, 6, 1, 0);
    add(0, 0, 5'b00000, 4'b0000, 0, 5'b00010, 20'h00040, 20'h00000, 20'h00000, 20'hFFFBF, 0, 6, 2, 0);
    // tail release on entry 0
    add(0, 0, 5'b00000, 4'b0000, 0, 5'b00000, 20'h00000, 20'h00001, 20'h00000, 20'hFFFBE, 0, 0, 4, 0);
    add(0, 1, 5'b00001, 4'b0001, 0, 5'b00000, 20'h00000, 20'h00000, 20'h00000, 20'hFFFBE, 0, 0, 3, 0);
    add(0, 1, 5'b00001, 4'b0001, 0, 5'b00000, 20'h00000, 20'h00000, 20'h00000, 20'hFFFBE, 0, 0, 2, 0);
    add(0, 1, 5'b00001, 4'b0001, 1, 5'b00000, 20'h00000, 20'h00000, 20'h00000, 20'hFFFBE, 0, 0, 1, 0);
    add(0, 0, 5'b00000, 4'b0000, 0, 5'b00001, 20'h00001, 20'h00000, 20'h00000, 20'hFFFBE, 0, 0, 2, 0);
    add(0, 0, 5'b00000, 4'b0000, 0, 5'b00001, 20'h00001, 20'h00000, 20'h00000, 20'hFFFBE, 0, 0, 3, 0);
    add(0, 0, 5'b00000, 4'b0000, 0, 5'b00001, 20'h00001, 20'h00000, 20'h00000, 20'hFFFBF, 0, 0, 4, 0);
    // tail plus credit at full count: straight back to FREE
    add(0, 0, 5'b00000, 4'b0000, 0, 5'b00000, 20'h00000, 20'h00001, 20'h00000, 20'hFFFBE, 0, 0, 4, 0);
    add(0, 1, 5'b00001, 4'b0001, 1, 5'b00001, 20'h00001, 20'h00000, 20'h00000, 20'hFFFBF, 0, 0, 4, 0);
    // overflow credit
    add(0, 0, 5'b00000, 4'b0000, 0, 5'b00001, 20'h00001, 20'h00000, 20'h00000, 20'hFFFBF, 1, 0, 4, 0);
    add(1, 0, 5'b00000, 4'b0000, 0, 5'b00000, 20'h00000, 20'h00000, 20'h00000, 20'hFFFFF, 0, 0, 4, 1);
    // allocate an entry that is already busy
    add(0, 0, 5'b00000, 4'b0000, 0, 5'b00000, 20'h00000, 20'h00008, 20'h00000, 20'hFFFF7, 0, 3, 4, 0);
    add(0, 0, 5'b00000, 4'b0000, 0, 5'b00000, 20'h00000, 20'h00008, 20'h00000, 20'hFFFF7, 1, 3, 4, 0);
    add(1, 0, 5'b00000, 4'b0000, 0, 5'b00000, 20'h00000, 20'h00000, 20'h00000, 20'hFFFFF, 0, 3, 4, 1);
    // send with a two-hot port
    add(0, 1, 5'b00011, 4'b0001, 0, 5'b00000, 20'h00000, 20'h00000, 20'h00000, 20'hFFFFF, 1, 0, 4, 1);
    add(1, 0, 5'b00000, 4'b0000, 0, 5'b00000, 20'h00000, 20'h00000, 20'h00000, 20'hFFFFF, 0, 0, 4, 1);
    // credit with a two-hot VC field is ignored
    add(0, 0, 5'b00000, 4'b0000, 0, 5'b00000, 20'h00000, 20'h00001, 20'h00000, 20'hFFFFE, 0, 0, 4, 0);
    add(0, 1, 5'b00001, 4'b0001, 0, 5'b00000, 20'h00000, 20'h00000, 20'h00000, 20'hFFFFE, 0, 0, 3, 0);
    add(0, 0, 5'b00000, 4'b0000, 0, 5'b00001, 20'h00003, 20'h00000, 20'h00000, 20'hFFFFE, 1, 0, 3, 0);
    add(1, 0, 5'b00000, 4'b0000, 0, 5'b00000, 20'h00000, 20'h00000, 20'h00000, 20'hFFFFF, 0, 0, 4, 1);
    // send on an unallocated VC still decrements
    add(0, 1, 5'b00001, 4'b0001, 0, 5'b00000, 20'h00000, 20'h00000, 20'h00000, 20'hFFFFF, 1, 0, 3, 0);

    for (int k = 0; k < vec_q.size(); k++) begin
      vec_t v;
      string tag;
      v = vec_q[k];
      drive(v.rst, v.sent, v.port, v.vc, v.tail, v.cval, v.cvc, v.alloc);
      tag = $sformatf("vec%0d", k);
      chk({tag, "_blocked"}, 32'(vc_blocked), 32'(v.e_blk));
      chk({tag, "_free"},    32'(vc_free),    32'(v.e_free));
      chk({tag, "_error"},   32'(error),      32'(v.e_err));
      chk({tag, "_count"},   32'(credit_count[v.idx*CW +: CW]), 32'(v.e_cnt));
      if (v.all4) chk_all4({tag, "_all_counts"});
    end

    // mid-packet reset: entries 0 and 5 drained to zero with tails sent
    drive(1, 0, '0, '0, 0, '0, '0, '0);
    drive(0, 0, '0, '0, 0, '0, '0, 20'h00021);
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(CW'(3 - k));
      exp_q.push_back(CW'(3 - k));
    end
    for (int k = 0; k < 4; k++) begin
      logic [CW-1:0] e;
      drive(0, 1, 5'b00001, 4'b0001, (k == 3), '0, '0, '0);
      e = exp_q.pop_front();
      chk($sformatf("mid_e0_send%0d", k), 32'(credit_count[0 +: CW]), 32'(e));
      drive(0, 1, 5'b00010, 4'b0010, (k == 3), '0, '0, '0);
      e = exp_q.pop_front();
      chk($sformatf("mid_e5_send%0d", k), 32'(credit_count[5*CW +: CW]), 32'(e));
    end
    chk("mid_blocked", 32'(vc_blocked), 32'h00021);
    chk("mid_free",    32'(vc_free),    32'hFFFDE);
    // one credit back while draining: not free yet; allocating it again is an error
    drive(0, 0, '0, '0, 0, 5'b00001, 20'h00001, 20'h00001);
    chk("mid_drain_cnt",  32'(credit_count[0 +: CW]), 32'd1);
    chk("mid_drain_free", 32'(vc_free), 32'hFFFDE);
    chk("mid_drain_err",  32'(error), 32'd1);
    drive(1, 0, '0, '0, 0, '0, '0, '0);
    drive(0, 0, '0, '0, 0, '0, '0, '0);
    chk_all4("mid_rst_counts");
    chk("mid_rst_free",    32'(vc_free),    32'hFFFFF);
    chk("mid_rst_blocked", 32'(vc_blocked), 32'h00000);
    chk("mid_rst_error",   32'(error),      32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vc_credit_tracker.md
Name: vc_credit_tracker

Overview:
- Per-output-port, per-VC credit counters for the router's output side.
- Produces the registered VC-blocked status vector consumed by the VC blocked-status selector and the switch allocator; index p*NV+v = output port p, VC v.
- Also tracks VC occupancy. A VC becomes free for reallocation only after its tail flit has left and every downstream buffer slot has been credited back.

Parameters:
NP, 5, number of output ports
NV, 4, number of VCs per port
BUF_DEPTH, 4, downstream buffer depth per VC (initial credits), >=1
CNT_W, 3, counter width; must satisfy 2**CNT_W > BUF_DEPTH

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-high
flit_sent  in  1  a flit leaves the switch this cycle
flit_port  in  NP  one-hot output port of departing flit
flit_vc  in  NV  one-hot output VC of departing flit
flit_tail  in  1  departing flit is a tail (qualified by flit_sent)
credit_valid  in  NP  credit returned from downstream, per port
credit_vc  in  NP*NV  one-hot VC of returned credit, field p at [p*NV +: NV]
vc_alloc  in  NP*NV  one-cycle pulse: VC granted to a new packet
vc_blocked  out  NP*NV  registered: 1 = zero credits
vc_free  out  NP*NV  registered: 1 = VC available for allocation
credit_count  out  NP*NV*CNT_W  registered counters, entry i at [i*CNT_W +: CNT_W]
error  out  1  sticky protocol-error flag

Behaviour:
- Reset (rst=1 at a clock edge) applies regardless of other inputs. It also applies mid-packet; pending releases are discarded.
  - All counts = BUF_DEPTH.
  - vc_blocked = 0.
  - vc_free = all 1.
  - tail_pending = 0.
  - error = 0.
- Per entry (p,v):
  - dec = flit_sent & flit_port[p] & flit_vc[v]
  - inc = credit_valid[p] & credit_vc[p*NV+v]
- Counter update:
  - dec & inc: count unchanged.
  - dec only: count-1.
  - inc only: count+1.
  - dec only at count 0 (underflow): count held at 0, error set.
  - inc only at count BUF_DEPTH (overflow): count held, error set.
- vc_blocked[i] <= (next_count[i]==0).
  - Latency is one cycle: a flit sent at count 1 makes the entry blocked on the next cycle.
  - Send plus credit at count 1 leaves the entry unblocked.
- VC state per entry, tracked by vc_free and tail_pending.
  - FREE (vc_free=1): vc_alloc[i] moves the entry to BUSY next cycle (vc_free=0).
  - BUSY (vc_free=0, tail_pending=0): dec & flit_tail moves the entry to DRAINING (tail_pending=1).
  - DRAINING: when next_count==BUF_DEPTH, the entry moves to FREE (vc_free=1, tail_pending=0) on that edge.
    - Tail sent with all credits returned in the same cycle, net count BUF_DEPTH: FREE directly on that edge.
- Protocol errors:
  - vc_alloc[i] while vc_free[i]=0: error set, state unchanged.
  - dec on an entry with vc_free=1 (flit on an unallocated VC): error set; count still updated.
  - flit_sent with flit_port or flit_vc not exactly one-hot: error set, no counter changes from the send.
  - credit_valid[p] with credit_vc field not one-hot: error set, that credit ignored.
- Credits on different ports in the same cycle are all applied. There is at most one send per cycle.
- error is sticky until reset. Outputs are never driven combinationally from inputs.

Test Plan:
- Defaults NP=5, NV=4, BUF_DEPTH=4.
- Reset check: hold rst 2 cycles, release -> every credit_count=4, vc_blocked=0x00000, vc_free=0xFFFFF, error=0.
- Drain to blocked: vc_alloc bit 6 (port1,VC2), then 4 back-to-back sends on port1/VC2 -> counts 3,2,1,0; vc_blocked[6]=1 the cycle after the 4th send; a 5th send -> error=1, count stays 0.
- Simultaneous send and credit: at count 1, send and credit the same entry together -> count stays 1, vc_blocked stays 0; next cycle credit only -> count 2.
- Tail release: allocate entry 0, send 3 flits with the last marked tail -> vc_free[0]=0 while count<4; 3 credits -> vc_free[0]=1 on the edge where count returns to 4, never earlier.
- Illegal inputs: vc_alloc an entry already busy -> error=1; separately after reset, flit_sent with flit_port=5'b00011 -> error=1, all counts unchanged.
- Reset mid-operation: with several entries at count 0 and DRAINING, assert rst for 1 cycle -> all counts=4, vc_free all 1, vc_blocked all 0, error=0 on the following cycle.
